// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared FSM/owner encodings and memory-window defaults
//               for the memory port arbiter and Imem.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    localparam int unsigned c_STATE_W = 2;
    localparam logic [c_STATE_W-1:0] c_ST_IDLE = 2'd0;
    localparam logic [c_STATE_W-1:0] c_ST_BUSY = 2'd1;
    localparam logic [c_STATE_W-1:0] c_ST_RESP = 2'd2;

    localparam logic c_OWN_FETCH = 1'b0;
    localparam logic c_OWN_DATA  = 1'b1;

    localparam logic [31:0] c_BOOT_ADDRESS = 32'h0000_1000;
    localparam logic [31:0] c_MEM_SIZE     = 32'h0000_1000;

endpackage
`default_nettype wire

// File: rtl/mem_addr_check.sv
`default_nettype none
// ============================================================================
// Module      : mem_addr_check
// Description : Combinational word-alignment and window check of one address.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_addr_check
    import mem_port_arbiter_pkg::*;
#(
    parameter int                      ADDRESS_SIZE = 32,
    parameter logic [ADDRESS_SIZE-1:0] BOOT_ADDRESS = ADDRESS_SIZE'(c_BOOT_ADDRESS),
    parameter logic [ADDRESS_SIZE-1:0] MEM_SIZE     = ADDRESS_SIZE'(c_MEM_SIZE)
) (
    input  logic [ADDRESS_SIZE-1:0] addr,
    output logic                    valid
);

    // One extra bit keeps BOOT_ADDRESS + MEM_SIZE from wrapping at the top of the map.
    localparam logic [ADDRESS_SIZE:0] c_LO = {1'b0, BOOT_ADDRESS};
    localparam logic [ADDRESS_SIZE:0] c_HI = {1'b0, BOOT_ADDRESS} + {1'b0, MEM_SIZE};

    logic [ADDRESS_SIZE:0] w_addr_ext;

    assign w_addr_ext = {1'b0, addr};
    assign valid      = (addr[1:0] == 2'b00) && (w_addr_ext >= c_LO) && (w_addr_ext < c_HI);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one req/ack memory port between fetch and data paths.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int                      ADDRESS_SIZE = 32,
    parameter int                      DATA_SIZE    = 32,
    parameter logic [ADDRESS_SIZE-1:0] BOOT_ADDRESS = ADDRESS_SIZE'(c_BOOT_ADDRESS),
    parameter logic [ADDRESS_SIZE-1:0] MEM_SIZE     = ADDRESS_SIZE'(c_MEM_SIZE),
    parameter int                      TIMEOUT      = 16,
    parameter int                      MAX_D_STREAK = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    if_req,
    input  logic [ADDRESS_SIZE-1:0] if_addr,
    output logic                    if_ack,
    output logic [DATA_SIZE-1:0]    if_rdata,
    output logic                    if_err,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [ADDRESS_SIZE-1:0] d_addr,
    input  logic [DATA_SIZE-1:0]    d_wdata,
    output logic                    d_ack,
    output logic [DATA_SIZE-1:0]    d_rdata,
    output logic                    d_err,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDRESS_SIZE-1:0] mem_addr,
    output logic [DATA_SIZE-1:0]    mem_wdata,
    input  logic                    mem_ack,
    input  logic [DATA_SIZE-1:0]    mem_rdata
);

    localparam int unsigned           c_TCNT_W     = $clog2(TIMEOUT + 1);
    localparam int unsigned           c_STRK_W     = $clog2(MAX_D_STREAK + 1);
    localparam logic [c_TCNT_W-1:0]   c_TIMEOUT    = c_TCNT_W'(TIMEOUT);
    localparam logic [c_STRK_W-1:0]   c_MAX_STREAK = c_STRK_W'(MAX_D_STREAK);

    logic [c_STATE_W-1:0]    r_state;
    logic [c_STATE_W-1:0]    w_state_nxt;
    logic                    r_owner;
    logic [c_STRK_W-1:0]     r_streak;
    logic [c_TCNT_W-1:0]     r_tcnt;
    logic [c_TCNT_W-1:0]     w_tcnt_inc;

    logic                    w_grant;
    logic                    w_pick_fetch;
    logic [ADDRESS_SIZE-1:0] w_win_addr;
    logic                    w_addr_valid;
    logic                    w_timeout;

    logic                    r_mem_req,  w_mem_req_nxt;
    logic                    r_mem_we,   w_mem_we_nxt;
    logic [ADDRESS_SIZE-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [DATA_SIZE-1:0]    r_mem_wdata, w_mem_wdata_nxt;

    logic                    w_resp;
    logic                    w_resp_owner;
    logic                    w_resp_err;
    logic [DATA_SIZE-1:0]    w_resp_rdata;

    logic                    r_if_ack, r_if_err, r_d_ack, r_d_err;
    logic [DATA_SIZE-1:0]    r_if_rdata, r_d_rdata;

    // Data normally wins; a fetch starved by a full data streak takes the next slot.
    assign w_grant      = if_req | d_req;
    assign w_pick_fetch = if_req & (~d_req | (r_streak == c_MAX_STREAK));
    assign w_win_addr   = w_pick_fetch ? if_addr : d_addr;
    assign w_tcnt_inc   = r_tcnt + c_TCNT_W'(1);
    assign w_timeout    = (w_tcnt_inc == c_TIMEOUT);

    mem_addr_check #(
        .ADDRESS_SIZE (ADDRESS_SIZE),
        .BOOT_ADDRESS (BOOT_ADDRESS),
        .MEM_SIZE     (MEM_SIZE)
    ) u_addr_check (
        .addr  (w_win_addr),
        .valid (w_addr_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_owner     <= c_OWN_FETCH;
            r_streak    <= '0;
            r_tcnt      <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_ack    <= 1'b0;
            r_if_err    <= 1'b0;
            r_if_rdata  <= '0;
            r_d_ack     <= 1'b0;
            r_d_err     <= 1'b0;
            r_d_rdata   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_if_ack    <= w_resp & (w_resp_owner == c_OWN_FETCH);
            r_if_err    <= w_resp & (w_resp_owner == c_OWN_FETCH) & w_resp_err;
            r_if_rdata  <= (w_resp && w_resp_owner == c_OWN_FETCH) ? w_resp_rdata : '0;
            r_d_ack     <= w_resp & (w_resp_owner == c_OWN_DATA);
            r_d_err     <= w_resp & (w_resp_owner == c_OWN_DATA) & w_resp_err;
            r_d_rdata   <= (w_resp && w_resp_owner == c_OWN_DATA) ? w_resp_rdata : '0;
            if (r_state == c_ST_IDLE) begin
                r_tcnt <= '0;
                if (w_grant) begin
                    r_owner <= w_pick_fetch ? c_OWN_FETCH : c_OWN_DATA;
                    if (w_pick_fetch || !if_req) begin
                        r_streak <= '0;
                    end else if (r_streak != c_MAX_STREAK) begin
                        r_streak <= r_streak + c_STRK_W'(1);
                    end
                end
            end else if (r_state == c_ST_BUSY) begin
                r_tcnt <= w_tcnt_inc;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (w_grant) w_state_nxt = w_addr_valid ? c_ST_BUSY : c_ST_RESP;
            c_ST_BUSY: if (mem_ack || w_timeout) w_state_nxt = c_ST_RESP;
            c_ST_RESP: w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_resp          = 1'b0;
        w_resp_owner    = r_owner;
        w_resp_err      = 1'b0;
        w_resp_rdata    = '0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_grant) begin
                    if (w_addr_valid) begin
                        w_mem_req_nxt   = 1'b1;
                        w_mem_we_nxt    = w_pick_fetch ? 1'b0 : d_we;
                        w_mem_addr_nxt  = w_win_addr;
                        w_mem_wdata_nxt = w_pick_fetch ? '0 : d_wdata;
                    end else begin
                        w_resp       = 1'b1;
                        w_resp_owner = w_pick_fetch ? c_OWN_FETCH : c_OWN_DATA;
                        w_resp_err   = 1'b1;
                    end
                end
            end
            c_ST_BUSY: begin
                // A simultaneous mem_ack beats the timeout.
                if (mem_ack) begin
                    w_mem_req_nxt = 1'b0;
                    w_mem_we_nxt  = 1'b0;
                    w_resp        = 1'b1;
                    w_resp_rdata  = r_mem_we ? '0 : mem_rdata;
                end else if (w_timeout) begin
                    w_mem_req_nxt = 1'b0;
                    w_mem_we_nxt  = 1'b0;
                    w_resp        = 1'b1;
                    w_resp_err    = 1'b1;
                end
            end
            default: begin
                w_resp = 1'b0;
            end
        endcase
    end

    assign if_ack    = r_if_ack;
    assign if_err    = r_if_err;
    assign if_rdata  = r_if_rdata;
    assign d_ack     = r_d_ack;
    assign d_err     = r_d_err;
    assign d_rdata   = r_d_rdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire
